// File: rtl/picomem_wb_bridge.sv
// picomem_wb_bridge
// PicoMem slave (0xC000_0000 slot) to Wishbone B3 classic master bridge.
// Each PicoMem request becomes exactly one Wishbone cycle; the response is
// returned on a single-cycle mem_s_ready pulse.
// Optional watchdog: define PICOMEM_WB_TIMEOUT_EN to terminate transfers that
// are never acknowledged after TIMEOUT_CYCLES cycles (reported as bus_err).
module picomem_wb_bridge #(
    parameter int unsigned ADDR_WIDTH     = 30,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_s_valid,
    output logic                  mem_s_ready,
    input  logic [31:0]           mem_s_addr,
    input  logic [31:0]           mem_s_wdata,
    input  logic [3:0]            mem_s_wstrb,
    output logic [31:0]           mem_s_rdata,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    output logic                  bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_t;

    state_t state;

    // Byte-offset bits and any address bits above the Wishbone word address
    // are intentionally not forwarded.
    logic unused_ok;
    assign unused_ok = &{1'b0, mem_s_addr, TIMEOUT_CYCLES[0]};

    // Watchdog expiry: counter reaches TIMEOUT_CYCLES-1 while in BUS, so the
    // timeout is taken on edge E(TIMEOUT_CYCLES) after the strobe rose at E0.
    logic wd_expired;
`ifdef PICOMEM_WB_TIMEOUT_EN
    localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wd_cnt;
    assign wd_expired = (wd_cnt == CNT_LAST);
`else
    assign wd_expired = 1'b0;
`endif

    // Bridge FSM: launches the Wishbone cycle, waits for ack/err/timeout,
    // then issues one registered response cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            mem_s_ready <= 1'b0;
            mem_s_rdata <= '0;
            bus_err     <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_sel_o    <= '0;
            wb_dat_o    <= '0;
`ifdef PICOMEM_WB_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    mem_s_ready <= 1'b0;
                    mem_s_rdata <= '0;
                    bus_err     <= 1'b0;
                    if (mem_s_valid) begin
                        wb_adr_o <= mem_s_addr[ADDR_WIDTH+1:2];
                        wb_dat_o <= mem_s_wdata;
                        wb_we_o  <= |mem_s_wstrb;
                        wb_sel_o <= (|mem_s_wstrb) ? mem_s_wstrb : 4'hF;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
`ifdef PICOMEM_WB_TIMEOUT_EN
                        wd_cnt   <= '0;
`endif
                        state    <= ST_BUS;
                    end
                end

                ST_BUS: begin
                    // Error (or timeout) takes priority over a simultaneous ack.
                    if (wb_err_i || wd_expired) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        mem_s_ready <= 1'b1;
                        mem_s_rdata <= ERR_RDATA;
                        bus_err     <= 1'b1;
                        state       <= ST_RESP;
                    end else if (wb_ack_i) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        mem_s_ready <= 1'b1;
                        mem_s_rdata <= wb_we_o ? '0 : wb_dat_i;
                        bus_err     <= 1'b0;
                        state       <= ST_RESP;
                    end else begin
`ifdef PICOMEM_WB_TIMEOUT_EN
                        wd_cnt      <= wd_cnt + CNT_W'(1);
`endif
                    end
                end

                ST_RESP: begin
                    // Request is not re-sampled here: the master still holds
                    // the completed request during this cycle.
                    mem_s_ready <= 1'b0;
                    mem_s_rdata <= '0;
                    bus_err     <= 1'b0;
                    state       <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picomem_wb_bridge.sv
// Directed testbench for picomem_wb_bridge (TIMEOUT_CYCLES overridden to 16).
module tb_picomem_wb_bridge;

    logic        clk;
    logic        reset;
    logic        mem_s_valid;
    logic        mem_s_ready;
    logic [31:0] mem_s_addr;
    logic [31:0] mem_s_wdata;
    logic [3:0]  mem_s_wstrb;
    logic [31:0] mem_s_rdata;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [29:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    picomem_wb_bridge #(
        .ADDR_WIDTH     (30),
        .TIMEOUT_CYCLES (16),
        .ERR_RDATA      (32'hFFFF_FFFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_s_valid (mem_s_valid),
        .mem_s_ready (mem_s_ready),
        .mem_s_addr  (mem_s_addr),
        .mem_s_wdata (mem_s_wdata),
        .mem_s_wstrb (mem_s_wstrb),
        .mem_s_rdata (mem_s_rdata),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_sel_o    (wb_sel_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge; outputs are then sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        if ({mem_s_ready, bus_err, wb_cyc_o, wb_stb_o, wb_we_o} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_s_ready, bus_err, wb_cyc_o, wb_stb_o, wb_we_o});
        end
        checks++;
        if ({mem_s_rdata, wb_dat_o, wb_adr_o, wb_sel_o} !== '0) begin
            errors++; $display("FAIL reset_data: rdata=%h dat=%h adr=%h sel=%h expected all 0", mem_s_rdata, wb_dat_o, wb_adr_o, wb_sel_o);
        end
        checks++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read_zero_wait();
        mem_s_addr  = 32'hC000_0010;
        mem_s_wstrb = 4'h0;
        mem_s_wdata = 32'hDEAD_BEEF;
        mem_s_valid = 1'b1;
        tick(); // E0
        if ({wb_cyc_o, wb_stb_o, wb_we_o, mem_s_ready} !== 4'b1100) begin
            errors++; $display("FAIL rd_launch: cyc/stb/we/ready=%b expected 1100", {wb_cyc_o, wb_stb_o, wb_we_o, mem_s_ready});
        end
        checks++;
        if (wb_adr_o !== 30'h3000_0004) begin
            errors++; $display("FAIL rd_adr: got %h expected 30000004", wb_adr_o);
        end
        checks++;
        if (wb_sel_o !== 4'hF) begin
            errors++; $display("FAIL rd_sel: got %h expected f", wb_sel_o);
        end
        checks++;
        wb_dat_i = 32'h1234_5678;
        wb_ack_i = 1'b1;
        tick(); // E1
        if ({mem_s_ready, bus_err, wb_cyc_o} !== 3'b100) begin
            errors++; $display("FAIL rd_resp: ready/err/cyc=%b expected 100", {mem_s_ready, bus_err, wb_cyc_o});
        end
        checks++;
        if (mem_s_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL rd_data: got %h expected 12345678", mem_s_rdata);
        end
        checks++;
        wb_ack_i    = 1'b0;
        mem_s_valid = 1'b0;
        tick(); // E2
        if ({mem_s_ready, mem_s_rdata} !== 33'b0) begin
            errors++; $display("FAIL rd_after: ready=%b rdata=%h expected 0/0", mem_s_ready, mem_s_rdata);
        end
        checks++;
    endtask

    task automatic test_write_wait3();
        int cyc_cnt;
        int rdy_cnt;
        cyc_cnt = 0;
        rdy_cnt = 0;
        mem_s_addr  = 32'hC000_0100;
        mem_s_wstrb = 4'b0100;
        mem_s_wdata = 32'h00AB_0000;
        mem_s_valid = 1'b1;
        tick(); // E0
        if ({wb_we_o, wb_sel_o, wb_dat_o, wb_adr_o} !== {1'b1, 4'b0100, 32'h00AB_0000, 30'h3000_0040}) begin
            errors++; $display("FAIL wr_launch: we=%b sel=%b dat=%h adr=%h expected 1/0100/00ab0000/30000040", wb_we_o, wb_sel_o, wb_dat_o, wb_adr_o);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            cyc_cnt += int'(wb_cyc_o);
            rdy_cnt += int'(mem_s_ready);
            tick(); // E1..E3
        end
        cyc_cnt += int'(wb_cyc_o);
        rdy_cnt += int'(mem_s_ready);
        wb_ack_i = 1'b1;
        tick(); // E4
        if ({mem_s_ready, bus_err, wb_cyc_o} !== 3'b100) begin
            errors++; $display("FAIL wr_resp: ready/err/cyc=%b expected 100", {mem_s_ready, bus_err, wb_cyc_o});
        end
        checks++;
        rdy_cnt += int'(mem_s_ready);
        wb_ack_i    = 1'b0;
        mem_s_valid = 1'b0;
        tick();
        rdy_cnt += int'(mem_s_ready);
        if (cyc_cnt !== 4) begin
            errors++; $display("FAIL wr_cyc_len: got %0d expected 4", cyc_cnt);
        end
        checks++;
        if (rdy_cnt !== 1) begin
            errors++; $display("FAIL wr_ready_cnt: got %0d expected 1", rdy_cnt);
        end
        checks++;
    endtask

    task automatic test_error();
        mem_s_addr  = 32'hC000_0020;
        mem_s_wstrb = 4'h0;
        mem_s_valid = 1'b1;
        tick(); // E0
        wb_dat_i = 32'h5555_AAAA;
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        tick(); // E1
        if ({mem_s_ready, bus_err, wb_cyc_o} !== 3'b110) begin
            errors++; $display("FAIL err_resp: ready/err/cyc=%b expected 110", {mem_s_ready, bus_err, wb_cyc_o});
        end
        checks++;
        if (mem_s_rdata !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL err_data: got %h expected ffffffff", mem_s_rdata);
        end
        checks++;
        wb_ack_i    = 1'b0;
        wb_err_i    = 1'b0;
        mem_s_valid = 1'b0;
        tick();
        if ({mem_s_ready, bus_err} !== 2'b00) begin
            errors++; $display("FAIL err_after: ready/err=%b expected 00", {mem_s_ready, bus_err});
        end
        checks++;
    endtask

    task automatic test_ack_outside_bus();
        int rdy_cnt;
        rdy_cnt = 0;
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            rdy_cnt += int'(mem_s_ready | bus_err | wb_cyc_o);
        end
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        if (rdy_cnt !== 0) begin
            errors++; $display("FAIL idle_ack: activity count %0d expected 0", rdy_cnt);
        end
        checks++;
    endtask

    task automatic test_timeout();
        int rdy_cnt;
        rdy_cnt = 0;
        mem_s_addr  = 32'hC000_0030;
        mem_s_wstrb = 4'h0;
        mem_s_valid = 1'b1;
        tick(); // E0
`ifdef PICOMEM_WB_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            tick(); // E1..E15
            rdy_cnt += int'(mem_s_ready | ~wb_cyc_o);
        end
        if (rdy_cnt !== 0) begin
            errors++; $display("FAIL to_early: early exit count %0d expected 0", rdy_cnt);
        end
        checks++;
        tick(); // E16
        if ({mem_s_ready, bus_err, wb_cyc_o} !== 3'b110) begin
            errors++; $display("FAIL to_resp: ready/err/cyc=%b expected 110", {mem_s_ready, bus_err, wb_cyc_o});
        end
        checks++;
        if (mem_s_rdata !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL to_data: got %h expected ffffffff", mem_s_rdata);
        end
        checks++;
        mem_s_valid = 1'b0;
        tick();
`else
        for (int i = 0; i < 1000; i++) begin
            tick();
            rdy_cnt += int'(mem_s_ready | bus_err);
        end
        if (rdy_cnt !== 0) begin
            errors++; $display("FAIL to_stall_ready: got %0d pulses expected 0", rdy_cnt);
        end
        checks++;
        if (wb_cyc_o !== 1'b1) begin
            errors++; $display("FAIL to_stall_cyc: got %b expected 1", wb_cyc_o);
        end
        checks++;
        mem_s_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`endif
    endtask

    task automatic test_back_to_back();
        mem_s_addr  = 32'hC000_0040;
        mem_s_wstrb = 4'h0;
        mem_s_valid = 1'b1;
        tick(); // E0
        wb_dat_i = 32'hCAFE_0001;
        wb_ack_i = 1'b1;
        tick(); // E1
        if ({mem_s_ready, mem_s_rdata} !== {1'b1, 32'hCAFE_0001}) begin
            errors++; $display("FAIL b2b_first: ready=%b rdata=%h expected 1/cafe0001", mem_s_ready, mem_s_rdata);
        end
        checks++;
        wb_ack_i = 1'b0;
        tick(); // E2: old request still held, must not be re-sampled
        if ({mem_s_ready, wb_cyc_o} !== 2'b00) begin
            errors++; $display("FAIL b2b_idle: ready/cyc=%b expected 00", {mem_s_ready, wb_cyc_o});
        end
        checks++;
        mem_s_addr  = 32'hC000_0044;
        mem_s_wstrb = 4'b0011;
        mem_s_wdata = 32'h0000_BEEF;
        tick(); // E3
        if ({wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o} !== {1'b1, 1'b1, 4'b0011, 30'h3000_0011}) begin
            errors++; $display("FAIL b2b_second: cyc=%b we=%b sel=%b adr=%h expected 1/1/0011/30000011", wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o);
        end
        checks++;
        wb_ack_i = 1'b1;
        tick(); // E4
        if ({mem_s_ready, bus_err} !== 2'b10) begin
            errors++; $display("FAIL b2b_second_resp: ready/err=%b expected 10", {mem_s_ready, bus_err});
        end
        checks++;
        wb_ack_i    = 1'b0;
        mem_s_valid = 1'b0;
        tick();
        if (mem_s_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_single: ready=%b expected 0", mem_s_ready);
        end
        checks++;
    endtask

    task automatic test_reset_mid_bus();
        mem_s_addr  = 32'hC000_0050;
        mem_s_wstrb = 4'hF;
        mem_s_wdata = 32'h1111_2222;
        mem_s_valid = 1'b1;
        tick(); // E0
        if (wb_cyc_o !== 1'b1) begin
            errors++; $display("FAIL rst_mid_launch: cyc=%b expected 1", wb_cyc_o);
        end
        checks++;
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        mem_s_valid = 1'b0;
        if ({mem_s_ready, bus_err, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_dat_o, wb_adr_o, mem_s_rdata} !== '0) begin
            errors++; $display("FAIL rst_mid_clear: ready=%b err=%b cyc=%b stb=%b we=%b sel=%h dat=%h adr=%h expected all 0", mem_s_ready, bus_err, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_dat_o, wb_adr_o);
        end
        checks++;
        tick();
        if ({mem_s_ready, wb_cyc_o} !== 2'b00) begin
            errors++; $display("FAIL rst_mid_noready: ready/cyc=%b expected 00", {mem_s_ready, wb_cyc_o});
        end
        checks++;
        mem_s_addr  = 32'hC000_0060;
        mem_s_wstrb = 4'h0;
        mem_s_valid = 1'b1;
        tick();
        wb_dat_i = 32'h0BAD_F00D;
        wb_ack_i = 1'b1;
        tick();
        if ({mem_s_ready, bus_err, mem_s_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
            errors++; $display("FAIL rst_mid_recover: ready=%b err=%b rdata=%h expected 1/0/0badf00d", mem_s_ready, bus_err, mem_s_rdata);
        end
        checks++;
        wb_ack_i    = 1'b0;
        mem_s_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        mem_s_valid = 1'b0;
        mem_s_addr  = '0;
        mem_s_wdata = '0;
        mem_s_wstrb = '0;
        wb_dat_i    = '0;
        wb_ack_i    = 1'b0;
        wb_err_i    = 1'b0;
        test_reset();
        test_read_zero_wait();
        test_write_wait3();
        test_error();
        test_ack_outside_bus();
        test_timeout();
        test_back_to_back();
        test_reset_mid_bus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation exceeded 200000 ns limit");
        $fatal(1);
    end

endmodule

// File: doc/picomem_wb_bridge.md
# picomem_wb_bridge

PicoMem-to-Wishbone bridge filling the 0xC000_0000 slot (S3) of the top-level PicoMem 1:4 mux. It is the responder for CPU accesses on that slot and converts each one into a single Wishbone classic (B3, non-pipelined) cycle toward external Wishbone peripherals. It returns read data, or a fixed error word, on a one-cycle `mem_s_ready` pulse. An optional watchdog completes transfers that Wishbone never acknowledges.

## Interface

Parameters:
- `ADDR_WIDTH`, 30: Wishbone word-address width; `wb_adr_o = mem_s_addr[ADDR_WIDTH+1:2]`.
- `TIMEOUT_CYCLES`, 255: maximum wait for `wb_ack_i`/`wb_err_i` (1..65535); used only with the watchdog.
- `ERR_RDATA`, 32'hFFFF_FFFF: read data returned on error or timeout.

Ports:
- `clk` in 1: system clock (sysclk domain); the only clock.
- `reset` in 1: synchronous, active-high reset.
- `mem_s_valid` in 1: PicoMem request valid.
- `mem_s_ready` out 1: PicoMem completion pulse.
- `mem_s_addr` in 32: byte address.
- `mem_s_wdata` in 32: write data.
- `mem_s_wstrb` in 4: byte strobes; 0 = read.
- `mem_s_rdata` out 32: read data, valid while `mem_s_ready`=1.
- `wb_cyc_o` out 1: Wishbone cycle.
- `wb_stb_o` out 1: Wishbone strobe.
- `wb_we_o` out 1: Wishbone write enable.
- `wb_adr_o` out ADDR_WIDTH: Wishbone word address.
- `wb_sel_o` out 4: Wishbone byte select.
- `wb_dat_o` out 32: Wishbone write data.
- `wb_dat_i` in 32: Wishbone read data.
- `wb_ack_i` in 1: Wishbone acknowledge.
- `wb_err_i` in 1: Wishbone error.
- `bus_err` out 1: one-cycle pulse coincident with `mem_s_ready` when a transfer ended by error or timeout.

## Operation

- FSM states:
  - IDLE: when `mem_s_valid`=1, latch addr/wdata/wstrb, set `wb_we_o = |wstrb`, set `wb_sel_o` = wstrb (4'hF for reads), assert `wb_cyc_o`/`wb_stb_o`, clear the watchdog counter, and go to BUS.
  - BUS: hold all Wishbone outputs stable. Exit on `wb_ack_i` (success), on `wb_err_i` (error), or on counter = TIMEOUT_CYCLES-1 (timeout). On exit, drop cyc/stb, register the response, and go to RESP.
  - RESP: `mem_s_ready`=1 for exactly one cycle, then return to IDLE.
- Response data:
  - Read success: `mem_s_rdata` = `wb_dat_i` captured on the ack edge.
  - Error or timeout: `mem_s_rdata` = ERR_RDATA and `bus_err`=1; any write is considered dropped.
- `wb_ack_i` and `wb_err_i` asserted together: error wins.
- `mem_s_rdata` is 0 whenever `mem_s_ready`=0.
- PicoMem master protocol: the master holds its request until ready and may present a new request the cycle after ready.
- IDLE is entered only after RESP, so the old request is never re-sampled.
- `mem_s_valid` dropping during BUS is a protocol violation; the bridge still completes the Wishbone cycle and pulses ready.
- Ack/err outside BUS is ignored.
- All outputs are registered.

## Timing

- Reset values: `mem_s_ready`=0, `mem_s_rdata`=0, `bus_err`=0, `wb_cyc_o`=`wb_stb_o`=`wb_we_o`=0, `wb_adr_o`=0, `wb_sel_o`=0, `wb_dat_o`=0, state IDLE, counter 0.
- Reset asserted mid-BUS: cyc/stb drop on the next edge; no ready is issued for the aborted transfer.
- Edge E0 samples valid in IDLE → cyc/stb high after E0.
- Slave acks in the same cycle → sampled at E1 → `mem_s_ready` high between E1 and E2. The minimum response is 2 cycles from valid to the ready sample.
- An ack N cycles after stb adds N cycles to the response.
- Watchdog: with stb first high after E0, a timeout is detected at edge E(TIMEOUT_CYCLES) and ready is high in the following cycle.
- Back-to-back transfers: at least one IDLE cycle between a ready pulse and the next cyc; cyc never stays high across transfers.

## Configuration

- Macro `PICOMEM_WB_TIMEOUT_EN`.
- Defined: the watchdog counter (width $clog2(TIMEOUT_CYCLES+1)) and the timeout exit are compiled in.
- Undefined: no counter. BUS exits only on ack/err, so a missing ack stalls the CPU indefinitely; TIMEOUT_CYCLES is unused and `bus_err` reflects only `wb_err_i`.

## Test plan

- Read, zero-wait slave: addr 0xC000_0010, wstrb 0 → `wb_adr_o`=0x3000_0004, `wb_sel_o`=4'hF, `wb_we_o`=0; slave returns 0x1234_5678 with immediate ack → `mem_s_ready` 2 cycles after valid, rdata 0x1234_5678, `bus_err`=0.
- Byte write with 3-cycle ack delay: wstrb 4'b0100, wdata 0x00AB_0000 → `wb_sel_o`=4'b0100, `wb_dat_o`=0x00AB_0000, cyc held 4 cycles, single ready pulse 5 cycles after valid.
- Error response: slave raises `wb_err_i` (with ack also set) on a read → rdata 0xFFFF_FFFF, `bus_err` pulses with ready.
- Timeout with `PICOMEM_WB_TIMEOUT_EN` and TIMEOUT_CYCLES=16: no ack → cyc drops after 16 cycles, ready and `bus_err` pulse, rdata 0xFFFF_FFFF; without the macro, no ready after 1000 cycles.
- Back-to-back: the master issues a second request the cycle after ready → exactly one IDLE cycle, then a second Wishbone cycle; each request gets exactly one ready.
- Reset mid-BUS: `reset` pulses while cyc is high → all outputs return to reset values the next cycle, no ready, and a following request completes normally.
